// File: rtl/gpio_bank_mm.sv
// Memory-mapped GPIO bank: per-channel OUT/IN/STATUS/IRQ_EN registers behind a
// pin synchroniser, edge detector with sticky W1C flags and a registered IRQ.
module gpio_bank_mm #(
   parameter int          NUM_CH      = 2,
   parameter int          GPIO_W      = 8,
   parameter logic [31:0] BASE_ADDR   = 32'h1001_0000,
   parameter int          SYNC_STAGES = 2,
   parameter int          EDGE_MODE   = 0
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     we_i,
   input  logic [31:0]              addr_i,
   input  logic [31:0]              wdata_i,
   output logic [31:0]              rdata_o,
   output logic                     sel_o,
   input  logic [NUM_CH*GPIO_W-1:0] gpio_i,
   output logic [NUM_CH*GPIO_W-1:0] gpio_o,
   output logic                     irq_o
);

   localparam int          W    = NUM_CH * GPIO_W;
   localparam logic [31:0] SPAN = 32'(16 * NUM_CH + 4);

   logic [W-1:0] r_sync [SYNC_STAGES];
   logic [W-1:0] r_prev;
   logic [W-1:0] r_out;
   logic [W-1:0] r_en;
   logic [W-1:0] r_status;
   logic         r_irq;

   logic [31:0]       w_off;
   logic              w_hit;
   logic              w_wr;
   logic [3:0]        w_ch;
   logic [1:0]        w_reg;
   logic [W-1:0]      w_in;
   logic [W-1:0]      w_event;
   logic [W-1:0]      w_mask;
   logic [W-1:0]      w_wrep;
   logic [W-1:0]      w_clr;
   logic [NUM_CH-1:0] w_sum;
   logic [GPIO_W-1:0] w_field;
   logic              w_unused;

   // Range check is done on the offset so the window never wraps past BASE_ADDR.
   assign w_off    = addr_i - BASE_ADDR;
   assign w_hit    = (addr_i >= BASE_ADDR) && (w_off < SPAN) && (addr_i[1:0] == 2'b00);
   assign w_wr     = we_i & w_hit;
   assign w_ch     = w_off[7:4];
   assign w_reg    = w_off[3:2];
   assign w_in     = r_sync[SYNC_STAGES-1];
   assign w_wrep   = {NUM_CH{wdata_i[GPIO_W-1:0]}};
   assign w_clr    = (w_wr && (w_reg == 2'd2)) ? (w_wrep & w_mask) : '0;
   assign w_unused = ^wdata_i;

   generate
      if (EDGE_MODE == 0) begin : g_rise
         assign w_event = w_in & ~r_prev;
      end else if (EDGE_MODE == 1) begin : g_fall
         assign w_event = ~w_in & r_prev;
      end else begin : g_both
         assign w_event = w_in ^ r_prev;
      end
   endgenerate

   // Channel lane mask is empty for the IRQ_SUM slot, so its writes fall away.
   always_comb begin
      w_mask = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         if (w_ch == 4'(k)) w_mask[k*GPIO_W +: GPIO_W] = '1;
      end
   end

   always_comb begin
      w_sum = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         w_sum[k] = |(r_status[k*GPIO_W +: GPIO_W] & r_en[k*GPIO_W +: GPIO_W]);
      end
   end

   always_comb begin
      w_field = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         if (w_ch == 4'(k)) begin
            case (w_reg)
               2'd0:    w_field = r_out[k*GPIO_W +: GPIO_W];
               2'd1:    w_field = w_in[k*GPIO_W +: GPIO_W];
               2'd2:    w_field = r_status[k*GPIO_W +: GPIO_W];
               default: w_field = r_en[k*GPIO_W +: GPIO_W];
            endcase
         end
      end
   end

   assign sel_o   = w_hit;
   assign rdata_o = !w_hit                 ? 32'd0 :
                    (w_ch == 4'(NUM_CH))   ? 32'(w_sum) :
                                             32'(w_field);

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= '0;
         r_prev <= '0;
      end else begin
         r_sync[0] <= gpio_i;
         for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
         r_prev <= w_in;
      end
   end

   // A new event overrides a same-cycle W1C of the same bit.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_out    <= '0;
         r_en     <= '0;
         r_status <= '0;
         r_irq    <= 1'b0;
      end else begin
         if (w_wr && (w_reg == 2'd0)) r_out <= (r_out & ~w_mask) | (w_wrep & w_mask);
         if (w_wr && (w_reg == 2'd3)) r_en  <= (r_en  & ~w_mask) | (w_wrep & w_mask);
         r_status <= (r_status & ~w_clr) | w_event;
         r_irq    <= |w_sum;
      end
   end

   assign gpio_o = r_out;
   assign irq_o  = r_irq;

endmodule
